// File: rtl/key_entry_sequencer.sv
// -----------------------------------------------------------------------------
// key_entry_sequencer
//
// Collects a fixed-length keypad code from the asynchronous kb_in/kb_recv strobe
// link and compares it with the stored code. It then issues one verdict on
// key_status, qualified by a single-cycle key_valid pulse. An inter-digit
// timeout discards stale partial entries. A run of consecutive wrong codes puts
// the block into a timed lockout, and all keypad activity is ignored during it.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   kb_in       digit value, stable while kb_recv is high
//   kb_recv     digit strobe, asynchronous to clk
//   code        stored code; digit 0 sits in the MSBs
//   mode_neg    1 = report a correct code as KEY_OKNEG (disarm request)
//   key_status  0 KEY_OK, 1 KEY_OKNEG, 2 KEY_ERROR, 3 NO_KEY
//   key_valid   one-cycle pulse, key_status is meaningful only while high
//   digit_cnt   digits accepted in the current entry
//   busy        entry in progress
//   locked      lockout active
// -----------------------------------------------------------------------------
module key_entry_sequencer #(
  parameter  int DIGITS      = 4,
  parameter  int DIGIT_W     = 2,
  parameter  int TIMEOUT_CYC = 50000,
  parameter  int MAX_FAILS   = 3,
  parameter  int LOCK_CYC    = 150000,
  localparam int CNT_W       = $clog2(DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIGIT_W-1:0]          kb_in,
  input  logic                        kb_recv,
  input  logic [DIGITS*DIGIT_W-1:0]   code,
  input  logic                        mode_neg,
  output logic [1:0]                  key_status,
  output logic                        key_valid,
  output logic [CNT_W-1:0]            digit_cnt,
  output logic                        busy,
  output logic                        locked
);

  localparam int TO_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam int LOCK_W = $clog2(LOCK_CYC) + 1;
  localparam int FAIL_W = $clog2(MAX_FAILS) + 1;

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_OKNEG = 2'd1;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_REPORT,
    S_LOCKOUT
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Input synchroniser and strobe edge detector. The edge detector keeps running
  // in every state. As a result, a strobe held high across the end of a lockout
  // or a report cycle never produces a late, buffered digit.
  // ---------------------------------------------------------------------------
  logic               recv_s1, recv_s2, recv_d;
  logic [DIGIT_W-1:0] din_s1, din_s2;
  logic               strobe;

  // NOTE: every flop in a clocked block uses non-blocking assignment. This keeps
  // each stage sampling the previous stage's value from before the edge, so the
  // register chain really is a chain and not a single wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_s1 <= 1'b0;
      recv_s2 <= 1'b0;
      recv_d  <= 1'b0;
      din_s1  <= '0;
      din_s2  <= '0;
    end else begin
      recv_s1 <= kb_recv;
      recv_s2 <= recv_s1;
      recv_d  <= recv_s2;
      din_s1  <= kb_in;
      din_s2  <= din_s1;
    end
  end

  assign strobe = recv_s2 & ~recv_d;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0]    to_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic               mismatch;
  logic [1:0]         status_q;

  // Code digit addressed by the current digit count. In IDLE the count is 0, so
  // the first digit compares against slice 0. The code is read per digit, so a
  // code change mid-entry affects only the digits that are still to come.
  logic [DIGIT_W-1:0] code_digit;
  // NOTE: each combinational output gets a default before any conditional
  // assignment. Without one, a path that assigns nothing would infer a latch.
  always_comb begin
    code_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_cnt == CNT_W'(i)) code_digit = code[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  logic              accept;
  logic              last_digit;
  logic              digit_ne;
  logic              mismatch_upd;
  logic              timeout_hit;
  logic              lock_done;
  logic [FAIL_W-1:0] fail_inc;
  logic              lock_trip;

  always_comb begin
    accept       = strobe && ((state == S_IDLE) || (state == S_COLLECT));
    last_digit   = (state == S_IDLE) ? (DIGITS == 1)
                                     : (digit_cnt == CNT_W'(DIGITS - 1));
    digit_ne     = (din_s2 != code_digit);
    // A wrong digit only sets a sticky flag. Collection continues to the end, so
    // the verdict timing is the same for right and wrong codes.
    mismatch_upd = (state == S_IDLE) ? digit_ne : (mismatch | digit_ne);
    // A strobe in the expiry cycle takes priority over the timeout.
    timeout_hit  = (state == S_COLLECT) && !strobe
                   && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    lock_done    = (lock_cnt == LOCK_W'(LOCK_CYC - 1));
    fail_inc     = (fail_cnt >= FAIL_W'(MAX_FAILS)) ? fail_cnt
                                                    : fail_cnt + FAIL_W'(1);
    lock_trip    = mismatch && (fail_inc >= FAIL_W'(MAX_FAILS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_cnt <= '0;
      to_cnt    <= '0;
      lock_cnt  <= '0;
      fail_cnt  <= '0;
      mismatch  <= 1'b0;
      status_q  <= NO_KEY;
    end else begin
      // Digit collection and verdict capture
      if (accept) begin
        digit_cnt <= digit_cnt + CNT_W'(1);
        mismatch  <= mismatch_upd;
        to_cnt    <= '0;
        if (last_digit) begin
          status_q <= mismatch_upd ? KEY_ERROR : (mode_neg ? KEY_OKNEG : KEY_OK);
        end
      end else if (timeout_hit) begin
        digit_cnt <= '0;
        to_cnt    <= '0;
      end else if (state == S_COLLECT) begin
        if (to_cnt != TO_W'(TIMEOUT_CYC)) to_cnt <= to_cnt + TO_W'(1);
      end else if (state == S_REPORT) begin
        digit_cnt <= '0;
      end

      // Consecutive-failure tracking
      if (state == S_REPORT) begin
        fail_cnt <= mismatch ? fail_inc : '0;
      end else if ((state == S_LOCKOUT) && lock_done) begin
        fail_cnt <= '0;
      end

      // Lockout timer
      if ((state == S_LOCKOUT) && !lock_done) lock_cnt <= lock_cnt + LOCK_W'(1);
      else                                    lock_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (strobe) state_nxt = (DIGITS == 1) ? S_REPORT : S_COLLECT;
      end
      S_COLLECT: begin
        if (strobe && last_digit) state_nxt = S_REPORT;
        else if (timeout_hit)     state_nxt = S_IDLE;
      end
      S_REPORT: begin
        state_nxt = lock_trip ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    key_valid  = (state == S_REPORT);
    key_status = key_valid ? status_q : NO_KEY;
    busy       = (state == S_COLLECT);
    locked     = (state == S_LOCKOUT);
  end

endmodule

// File: tb/tb_key_entry_sequencer.sv
module tb_key_entry_sequencer;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 2;
  localparam int TIMEOUT_CYC = 10;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYC    = 60;
  localparam int CNT_W       = $clog2(DIGITS + 1);
  localparam int CODE_W      = DIGITS * DIGIT_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [DIGIT_W-1:0]    kb_in;
  logic                  kb_recv;
  logic [CODE_W-1:0]     code;
  logic                  mode_neg;
  logic [1:0]            key_status;
  logic                  key_valid;
  logic [CNT_W-1:0]      digit_cnt;
  logic                  busy;
  logic                  locked;

  int total = 0;
  int bad   = 0;

  // Monitor state (sampled on the rising edge, read by the tests on the falling edge)
  int         valid_cnt   = 0;
  int         lock_cycles = 0;
  logic [1:0] last_status;

  // Reference model state: consecutive wrong entries since the last success / reset / lockout
  int model_fails = 0;

  key_entry_sequencer #(
    .DIGITS      (DIGITS),
    .DIGIT_W     (DIGIT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYC    (LOCK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kb_in      (kb_in),
    .kb_recv    (kb_recv),
    .code       (code),
    .mode_neg   (mode_neg),
    .key_status (key_status),
    .key_valid  (key_valid),
    .digit_cnt  (digit_cnt),
    .busy       (busy),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_valid) begin
      valid_cnt   <= valid_cnt + 1;
      last_status <= key_status;
    end
    if (locked) lock_cycles <= lock_cycles + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Verdict for a whole entry: any difference anywhere is an error.
  function automatic logic [1:0] ref_verdict(input logic [CODE_W-1:0] c,
                                             input logic [CODE_W-1:0] entry,
                                             input logic neg);
    if (entry != c) return 2'd2;
    return neg ? 2'd1 : 2'd0;
  endfunction

  // One keypress: pin high for 2 cycles, low for 2 cycles.
  task automatic press(input logic [DIGIT_W-1:0] d);
    kb_in   = d;
    kb_recv = 1'b1;
    repeat (2) @(negedge clk);
    kb_recv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Full entry with checks against the reference model.
  task automatic enter(input logic [CODE_W-1:0] entry, input logic neg, input string tag);
    int         v0;
    logic [1:0] exp;
    v0       = valid_cnt;
    mode_neg = neg;
    exp      = ref_verdict(code, entry, neg);
    for (int i = 0; i < DIGITS; i++) begin
      press(entry[(DIGITS-1-i)*DIGIT_W +: DIGIT_W]);
      total++;
      if (digit_cnt !== CNT_W'((i < DIGITS-1) ? i + 1 : 0)) begin
        bad++;
        $display("FAIL %s digit_cnt after digit %0d: got %0d want %0d", tag, i, digit_cnt,
                 (i < DIGITS-1) ? i + 1 : 0);
      end
      if (i < DIGITS-1) begin
        total++;
        if (valid_cnt !== v0) begin
          bad++;
          $display("FAIL %s early verdict after digit %0d: got %0d pulses want 0", tag, i, valid_cnt - v0);
        end
      end
    end
    total++;
    if (valid_cnt !== v0 + 1) begin
      bad++;
      $display("FAIL %s verdict pulses: got %0d want 1", tag, valid_cnt - v0);
    end
    total++;
    if (last_status !== exp) begin
      bad++;
      $display("FAIL %s key_status: got %0d want %0d", tag, last_status, exp);
    end
    total++;
    if (key_status !== 2'd3) begin
      bad++;
      $display("FAIL %s status after verdict: got %0d want 3", tag, key_status);
    end
    if (exp == 2'd2) model_fails++;
    else             model_fails = 0;
    total++;
    if (locked !== (model_fails >= MAX_FAILS)) begin
      bad++;
      $display("FAIL %s locked: got %0b want %0b", tag, locked, model_fails >= MAX_FAILS);
    end
  endtask

  task automatic wait_unlock();
    int n = 0;
    while (locked === 1'b1 && n < LOCK_CYC + 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL unlock: locked still %0b after %0d cycles", locked, n);
    end
    model_fails = 0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    kb_recv  = 1'b0;
    kb_in    = '0;
    code     = 8'b00_01_10_11;
    mode_neg = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({key_status, key_valid, digit_cnt, busy, locked} !== {2'd3, 1'b0, CNT_W'(0), 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset outputs: status=%0d valid=%0b cnt=%0d busy=%0b locked=%0b", key_status,
               key_valid, digit_cnt, busy, locked);
    end
    rst_n = 1'b1;
    model_fails = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    code = 8'b00_01_10_11;
    enter(8'b00_01_10_11, 1'b0, "T1 ok");
    enter(8'b00_01_10_11, 1'b1, "T2 okneg");
    enter(8'b00_01_10_10, 1'b0, "T2 wrong last");
    enter(8'b00_01_10_11, 1'b0, "T2 recover");
  endtask

  task automatic test_lockout();
    int lc0;
    code = 8'b00_01_10_11;
    lc0  = lock_cycles;
    enter(8'b11_01_10_11, 1'b0, "T3 wrong1");
    enter(8'b00_00_10_11, 1'b0, "T3 wrong2");
    enter(8'b00_01_10_00, 1'b0, "T3 wrong3");
    for (int k = 0; k < 3; k++) begin
      press(2'(k));
      total++;
      if (digit_cnt !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL T3 strobe in lockout %0d: cnt=%0d busy=%0b want 0 0", k, digit_cnt, busy);
      end
    end
    wait_unlock();
    total++;
    if (lock_cycles - lc0 !== LOCK_CYC) begin
      bad++;
      $display("FAIL T3 lock length: got %0d want %0d", lock_cycles - lc0, LOCK_CYC);
    end
    enter(8'b00_01_10_11, 1'b0, "T3 after lock");
  endtask

  task automatic test_timeout();
    int v0;
    code = 8'b00_01_10_11;
    v0   = valid_cnt;
    // Plain timeout: idle until one cycle before expiry, then past it
    press(2'd0);
    press(2'd1);
    repeat (8) @(negedge clk);
    total++;
    if (digit_cnt !== CNT_W'(2) || busy !== 1'b1) begin
      bad++;
      $display("FAIL T4 before expiry: cnt=%0d busy=%0b want 2 1", digit_cnt, busy);
    end
    @(negedge clk);
    total++;
    if (digit_cnt !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL T4 after expiry: cnt=%0d busy=%0b want 0 0", digit_cnt, busy);
    end
    total++;
    if (valid_cnt !== v0) begin
      bad++;
      $display("FAIL T4 timeout verdict: got %0d pulses want 0", valid_cnt - v0);
    end
    // Strobe lands exactly in the expiry cycle: accepted
    press(2'd0);
    press(2'd1);
    repeat (6) @(negedge clk);
    press(2'd2);
    total++;
    if (digit_cnt !== CNT_W'(3)) begin
      bad++;
      $display("FAIL T4 expiry-cycle strobe: cnt=%0d want 3", digit_cnt);
    end
    press(2'd3);
    total++;
    if (valid_cnt !== v0 + 1 || last_status !== 2'd0) begin
      bad++;
      $display("FAIL T4 completed entry: pulses=%0d status=%0d want 1 0", valid_cnt - v0, last_status);
    end
    model_fails = 0;
    // Strobe one cycle after expiry: starts a fresh entry instead
    press(2'd0);
    press(2'd1);
    repeat (7) @(negedge clk);
    press(2'd2);
    total++;
    if (digit_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL T4 late strobe: cnt=%0d want 1", digit_cnt);
    end
    repeat (TIMEOUT_CYC + 2) @(negedge clk);
    total++;
    if (digit_cnt !== '0 || valid_cnt !== v0 + 1) begin
      bad++;
      $display("FAIL T4 late entry cleanup: cnt=%0d pulses=%0d want 0 1", digit_cnt, valid_cnt - v0);
    end
  endtask

  task automatic test_hold_and_reset();
    int         rises = 0;
    int         v0;
    logic [CNT_W-1:0] prev;
    code  = 8'b00_01_10_11;
    v0    = valid_cnt;
    prev  = digit_cnt;
    kb_in   = 2'd0;
    kb_recv = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) kb_recv = 1'b0;
      @(negedge clk);
      if (digit_cnt == CNT_W'(1) && prev == '0) rises++;
      prev = digit_cnt;
    end
    total++;
    if (rises !== 1) begin
      bad++;
      $display("FAIL T5 held strobe: got %0d accepted digits want 1", rises);
    end
    total++;
    if (digit_cnt !== '0 || valid_cnt !== v0) begin
      bad++;
      $display("FAIL T5 held strobe cleanup: cnt=%0d pulses=%0d want 0 0", digit_cnt, valid_cnt - v0);
    end
    // Two wrong entries, then reset mid-entry: reset must clear the fail count too
    enter(8'b11_11_11_11, 1'b0, "T5 wrong1");
    enter(8'b11_11_11_10, 1'b0, "T5 wrong2");
    v0 = valid_cnt;
    press(2'd0);
    press(2'd1);
    rst_n = 1'b0;
    #1;
    total++;
    if ({key_status, key_valid, digit_cnt, busy, locked} !== {2'd3, 1'b0, CNT_W'(0), 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL T5 mid-entry reset: status=%0d valid=%0b cnt=%0d busy=%0b locked=%0b", key_status,
               key_valid, digit_cnt, busy, locked);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_fails = 0;
    repeat (3) @(negedge clk);
    total++;
    if (valid_cnt !== v0 || digit_cnt !== '0) begin
      bad++;
      $display("FAIL T5 after reset: pulses=%0d cnt=%0d want 0 0", valid_cnt - v0, digit_cnt);
    end
    enter(8'b01_01_01_01, 1'b0, "T5 wrong after reset");
    enter(8'b00_01_10_11, 1'b0, "T5 ok after reset");
  endtask

  task automatic test_fail_clear();
    code = 8'b10_00_11_01;
    enter(8'b10_00_11_00, 1'b0, "T6 wrong1");
    enter(8'b00_00_11_01, 1'b0, "T6 wrong2");
    enter(8'b10_00_11_01, 1'b0, "T6 ok");
    enter(8'b10_10_11_01, 1'b0, "T6 wrong3");
    enter(8'b10_00_01_01, 1'b1, "T6 wrong4");
    enter(8'b01_00_11_01, 1'b0, "T6 wrong5");
    wait_unlock();
  endtask

  task automatic test_random();
    logic [CODE_W-1:0] entry;
    logic              neg;
    for (int n = 0; n < 40; n++) begin
      code  = CODE_W'($urandom);
      entry = ($urandom_range(0, 1) == 1) ? code : CODE_W'($urandom);
      neg   = 1'($urandom_range(0, 1));
      enter(entry, neg, "random");
      if (model_fails >= MAX_FAILS) wait_unlock();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lockout();
    test_timeout();
    test_hold_and_reset();
    test_fail_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
